// File: rtl/saes_pkg.sv
// Shared types and S-AES primitives for the CBC encryptor.
// The nibble helpers take the state column-major: [15:12]=s00, [11:8]=s10, [7:4]=s01, [3:0]=s11.
package saes_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef logic [15:0] block_t;

   localparam logic [7:0] RCON1 = 8'h80;
   localparam logic [7:0] RCON2 = 8'h30;

   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] r;
      case (n)
         4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
         4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
         4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
         4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  default: r = 4'h7;
      endcase
      return r;
   endfunction

   // SubNib(RotNib(w)) used by the key schedule
   function automatic logic [7:0] sub_rot(input logic [7:0] w);
      return {sbox(w[3:0]), sbox(w[7:4])};
   endfunction

   function automatic block_t sub_nib(input block_t s);
      return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
   endfunction

   function automatic block_t shift_rows(input block_t s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   // multiply by x in GF(2^4) modulo x^4 + x + 1
   function automatic logic [3:0] xtime(input logic [3:0] n);
      return {n[2:0], 1'b0} ^ {2'b00, n[3], n[3]};
   endfunction

   function automatic logic [3:0] mul4(input logic [3:0] n);
      return xtime(xtime(n));
   endfunction

   function automatic block_t mix_cols(input block_t s);
      return {s[15:12] ^ mul4(s[11:8]), mul4(s[15:12]) ^ s[11:8],
              s[7:4]   ^ mul4(s[3:0]),  mul4(s[7:4])   ^ s[3:0]};
   endfunction

endpackage

// File: rtl/saes_cbc_enc_if.sv
// Plaintext-in / ciphertext-out valid-ready stream of the CBC encryptor.
interface saes_cbc_enc_if;
   logic                in_valid;
   logic                in_ready;
   saes_pkg::block_t    in_data;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   saes_pkg::block_t    out_data;
   logic                out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/S_AES_Encryption.sv
// Combinational two-round S-AES encryption with the key schedule expanded on the fly.
module S_AES_Encryption
   import saes_pkg::*;
(
   input  block_t key,
   input  block_t plaintext,
   output block_t ciphertext
);
   logic [7:0] w2, w3, w4, w5;
   block_t     round1;

   assign w2 = key[15:8] ^ RCON1 ^ sub_rot(key[7:0]);
   assign w3 = w2 ^ key[7:0];
   assign w4 = w2 ^ RCON2 ^ sub_rot(w3);
   assign w5 = w4 ^ w3;

   assign round1     = mix_cols(shift_rows(sub_nib(plaintext ^ key))) ^ {w2, w3};
   assign ciphertext = shift_rows(sub_nib(round1)) ^ {w4, w5};
endmodule

// File: rtl/saes_cbc_enc.sv
// S-AES CBC encryptor: one block per cycle, ciphertext registered one cycle after input handshake.
//   state | meaning
//   IDLE  | no message open, waiting for start
//   RUN   | accepting plaintext blocks
//   DRAIN | last block accepted, waiting for its ciphertext to be taken
module saes_cbc_enc
   import saes_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  block_t           key_in,
   input  block_t           iv_in,
   output logic             busy,
   output logic [CNT_W-1:0] blk_count,
   saes_cbc_enc_if.slave    bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   block_t key_reg;
   block_t chain_reg;
   block_t cipher;
   logic   in_hs;
   logic   out_hs;

   assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
   assign busy         = (state != IDLE);
   assign in_hs        = bus.in_valid && bus.in_ready;
   assign out_hs       = bus.out_valid && bus.out_ready;

   S_AES_Encryption u_core (
      .key        (key_reg),
      .plaintext  (bus.in_data ^ chain_reg),
      .ciphertext (cipher)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         key_reg       <= '0;
         chain_reg     <= '0;
         blk_count     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  key_reg   <= key_in;
                  chain_reg <= iv_in;
                  blk_count <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (in_hs && bus.in_last) state <= DRAIN;
            end
            DRAIN: begin
               if (out_hs && bus.out_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // in_hs only occurs in RUN, so it never collides with the start load above
         if (in_hs) begin
            bus.out_data  <= cipher;
            chain_reg     <= cipher;
            bus.out_last  <= bus.in_last;
            bus.out_valid <= 1'b1;
            if (blk_count != CNT_MAX) blk_count <= blk_count + CNT_W'(1);
         end else if (out_hs) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule
